// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler
//   Shares the single VRAM write port between NUM_REQ drawing clients
//   (round-robin, burst req/gnt/ack handshake) and a background-clear engine
//   that refills the whole buffer with BG_COLOR once per frame. All writes
//   are gated to the display write window (i_blank).
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_vsync_start    frame-start pulse, requests a clear
//   i_blank          1 = VRAM write window open
//   i_req/i_last     per-client beat request / end-of-burst marker
//   i_addr/i_data    per-client packed address / pixel slices
//   o_gnt            registered one-hot grant
//   o_ack            combinational beat accept (o_gnt & i_req & i_blank)
//   o_we/o_addr/o_data  registered VRAM write port
//   o_busy           state is CLEAR or GRANT
//   o_clear_done     pulse with the final clear write
//   o_drop           pulse: accepted client beat addressed beyond DEPTH-1
module vram_write_scheduler #(
   parameter int unsigned           ADDR_WIDTH = 8,
   parameter int unsigned           DATA_WIDTH = 4,
   parameter int unsigned           DEPTH      = 256,
   parameter int unsigned           NUM_REQ    = 2,
   parameter logic [DATA_WIDTH-1:0] BG_COLOR   = '0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            i_vsync_start,
   input  logic                            i_blank,
   input  logic [NUM_REQ-1:0]              i_req,
   input  logic [NUM_REQ-1:0]              i_last,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   i_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_data,
   output logic [NUM_REQ-1:0]              o_gnt,
   output logic [NUM_REQ-1:0]              o_ack,
   output logic                            o_we,
   output logic [ADDR_WIDTH-1:0]           o_addr,
   output logic [DATA_WIDTH-1:0]           o_data,
   output logic                            o_busy,
   output logic                            o_clear_done,
   output logic                            o_drop
);

   localparam int unsigned           PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, CLEAR, GRANT} state_t;

   state_t                  r_state, w_state_nxt;
   logic [NUM_REQ-1:0]      r_gnt, w_gnt_nxt;
   logic [PW-1:0]           r_rr, w_rr_nxt;
   logic [PW-1:0]           r_gidx, w_gidx_nxt;
   logic [ADDR_WIDTH-1:0]   r_cnt, w_cnt_nxt;
   logic                    r_pend, w_pend_nxt;
   logic                    r_we, w_we_nxt;
   logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
   logic [DATA_WIDTH-1:0]   r_data, w_data_nxt;
   logic                    r_done, w_done_nxt;
   logic                    r_drop, w_drop_nxt;

   logic                    w_found;
   logic [PW-1:0]           w_win;
   logic [NUM_REQ-1:0]      w_ack;
   logic [ADDR_WIDTH-1:0]   w_sel_addr;
   logic [DATA_WIDTH-1:0]   w_sel_data;
   logic                    w_in_range;

   assign w_ack      = r_gnt & i_req & {NUM_REQ{i_blank}};
   assign w_sel_addr = i_addr[32'(r_gidx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign w_sel_data = i_data[32'(r_gidx)*DATA_WIDTH +: DATA_WIDTH];
   // Compare at 32 bits so DEPTH == 2^ADDR_WIDTH never truncates.
   assign w_in_range = (32'(w_sel_addr) < DEPTH);

   // Round-robin: first requester strictly after the pointer, wrapping.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         if (!w_found && i_req[PW'((32'(r_rr) + i) % NUM_REQ)]) begin
            w_found = 1'b1;
            w_win   = PW'((32'(r_rr) + i) % NUM_REQ);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_rr_nxt    = r_rr;
      w_gidx_nxt  = r_gidx;
      w_cnt_nxt   = r_cnt;
      w_pend_nxt  = r_pend;
      w_we_nxt    = 1'b0;
      w_addr_nxt  = r_addr;
      w_data_nxt  = r_data;
      w_done_nxt  = 1'b0;
      w_drop_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            // A same-cycle vsync pulse counts as pending; clear wins over clients.
            if (r_pend || i_vsync_start) begin
               w_state_nxt = CLEAR;
               w_pend_nxt  = 1'b0;
            end else if (w_found) begin
               w_state_nxt = GRANT;
               w_gidx_nxt  = w_win;
               w_gnt_nxt   = NUM_REQ'(1) << w_win;
            end
         end
         CLEAR: begin
            // vsync is deliberately ignored here: a running clear is not restarted.
            if (i_blank) begin
               w_we_nxt   = 1'b1;
               w_addr_nxt = r_cnt;
               w_data_nxt = BG_COLOR;
               if (r_cnt == LAST_ADDR) begin
                  w_done_nxt  = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
               end
            end
         end
         GRANT: begin
            if (i_vsync_start) w_pend_nxt = 1'b1;
            if (!i_req[r_gidx]) begin
               w_state_nxt = IDLE;
               w_gnt_nxt   = '0;
               w_rr_nxt    = r_gidx;
            end else if (i_blank) begin
               if (w_in_range) begin
                  w_we_nxt   = 1'b1;
                  w_addr_nxt = w_sel_addr;
                  w_data_nxt = w_sel_data;
               end else begin
                  w_drop_nxt = 1'b1;
               end
               if (i_last[r_gidx]) begin
                  w_state_nxt = IDLE;
                  w_gnt_nxt   = '0;
                  w_rr_nxt    = r_gidx;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_rr    <= PW'(NUM_REQ - 1);
         r_gidx  <= '0;
         r_cnt   <= '0;
         r_pend  <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_done  <= 1'b0;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_rr    <= w_rr_nxt;
         r_gidx  <= w_gidx_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pend  <= w_pend_nxt;
         r_we    <= w_we_nxt;
         r_addr  <= w_addr_nxt;
         r_data  <= w_data_nxt;
         r_done  <= w_done_nxt;
         r_drop  <= w_drop_nxt;
      end
   end

   assign o_gnt        = r_gnt;
   assign o_ack        = w_ack;
   assign o_we         = r_we;
   assign o_addr       = r_addr;
   assign o_data       = r_data;
   assign o_busy       = (r_state != IDLE);
   assign o_clear_done = r_done;
   assign o_drop       = r_drop;

endmodule
